// File: rtl/ad9252_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ad9252_spi_master                                          |
// | Description : 3-wire SPI master for the AD9252 configuration port.       |
// |               Sends a 24-bit frame (16-bit instruction + 1 data byte),   |
// |               tri-states SDIO for the data byte of reads and returns it. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ad9252_spi_master #(
  parameter int CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] adc_data,
  input  logic        start,
  output logic        busy_9252,
  output logic        spi_csb,
  output logic        spi_sclk,
  output logic        spi_sdio_o,
  output logic        spi_sdio_oe,
  input  logic        spi_sdio_i,
  output logic [7:0]  rd_data,
  output logic        rd_valid
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_clk_div_check
    $error("ad9252_spi_master: CLK_DIV must be in 2..255");
  end

  localparam int CW = 9;
  localparam logic [CW-1:0] C_HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_GAP  = CW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0]    bit_cnt, bit_cnt_nxt;
  logic [23:0]   shreg, shreg_nxt;
  logic          rw, rw_nxt;
  logic [7:0]    rx, rx_nxt;
  logic          busy_nxt, csb_nxt, sclk_nxt, sdio_nxt, oe_nxt;
  logic [7:0]    rd_data_nxt;
  logic          rd_valid_nxt;
  logic [23:0]   frame;

  // Instruction fields the frame does not carry are deliberately dropped.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{adc_data[30:24], adc_data[7:0]};

  // Reads carry no data byte; the slot is zero while SDIO is released anyway.
  assign frame = {adc_data[31], 2'b00, 5'b00000, adc_data[23:16],
                  adc_data[31] ? 8'h00 : adc_data[15:8]};

  // State, counters and all pin-facing outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rw          <= 1'b0;
      rx          <= 8'h00;
      busy_9252   <= 1'b0;
      spi_csb     <= 1'b1;
      spi_sclk    <= 1'b0;
      spi_sdio_o  <= 1'b0;
      spi_sdio_oe <= 1'b0;
      rd_data     <= 8'h00;
      rd_valid    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shreg       <= shreg_nxt;
      rw          <= rw_nxt;
      rx          <= rx_nxt;
      busy_9252   <= busy_nxt;
      spi_csb     <= csb_nxt;
      spi_sclk    <= sclk_nxt;
      spi_sdio_o  <= sdio_nxt;
      spi_sdio_oe <= oe_nxt;
      rd_data     <= rd_data_nxt;
      rd_valid    <= rd_valid_nxt;
    end
  end

  // Next-state logic; SCLK doubles as the low/high phase flag inside a bit window.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    rw_nxt       = rw;
    rx_nxt       = rx;
    busy_nxt     = busy_9252;
    csb_nxt      = spi_csb;
    sclk_nxt     = spi_sclk;
    sdio_nxt     = spi_sdio_o;
    oe_nxt       = spi_sdio_oe;
    rd_data_nxt  = rd_data;
    rd_valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          cnt_nxt   = C_HALF;
          shreg_nxt = frame;
          rw_nxt    = adc_data[31];
          busy_nxt  = 1'b1;
          csb_nxt   = 1'b0;
          oe_nxt    = 1'b1;
          sdio_nxt  = frame[23];
        end
      end

      SETUP: begin
        if (cnt == '0) begin
          state_nxt   = SHIFT;
          cnt_nxt     = C_HALF;
          bit_cnt_nxt = 5'd23;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      SHIFT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (!spi_sclk) begin
          sclk_nxt = 1'b1;
          cnt_nxt  = C_HALF;
        end else begin
          // Last cycle of the high phase: sample the ADC, then start the next window.
          if (rw && bit_cnt < 5'd8) begin
            rx_nxt = {rx[6:0], spi_sdio_i};
          end
          sclk_nxt = 1'b0;
          cnt_nxt  = C_HALF;
          if (bit_cnt == 5'd0) begin
            state_nxt = HOLD;
            if (rw) begin
              rd_data_nxt  = {rx[6:0], spi_sdio_i};
              rd_valid_nxt = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt - 1'b1;
            shreg_nxt   = {shreg[22:0], 1'b0};
            sdio_nxt    = shreg[22];
            if (rw && bit_cnt == 5'd8) begin
              oe_nxt = 1'b0;
            end
          end
        end
      end

      HOLD: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = C_GAP;
          csb_nxt   = 1'b1;
          oe_nxt    = 1'b0;
          sdio_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ad9252_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ad9252_spi_master                                       |
// | Description : Scoreboard bench for ad9252_spi_master, one instance at    |
// |               CLK_DIV=8 and one at CLK_DIV=2, with an ADC read model.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ad9252_spi_master;

  typedef struct {
    logic        rw;
    logic [23:0] fr;
    int          edges;
    int          busy;
    int          oe_low;
    int          gap;
    int          rv_cnt;
    int          rv_at;
    logic [7:0]  rdd;
  } rec_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  start, busy, csb, sclk, sdio_o, oe, sdio_i, rd_valid;
  logic [31:0] adc_data [2];
  logic [7:0]  rd_data  [2];
  logic [7:0]  adc_byte [2];

  rec_t exp_a[$], exp_b[$], obs_a[$], obs_b[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = (g == 0) ? 8 : 2;

    ad9252_spi_master #(.CLK_DIV(D)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .adc_data   (adc_data[g]),
      .start      (start[g]),
      .busy_9252  (busy[g]),
      .spi_csb    (csb[g]),
      .spi_sclk   (sclk[g]),
      .spi_sdio_o (sdio_o[g]),
      .spi_sdio_oe(oe[g]),
      .spi_sdio_i (sdio_i[g]),
      .rd_data    (rd_data[g]),
      .rd_valid   (rd_valid[g])
    );

    int          edges = 0, busy_cyc = 0, oe_low = 0, gap = 0, rv_cnt = 0, rv_at = 0;
    logic [23:0] fr = '0;
    logic [7:0]  rdd = '0;
    logic        p_sclk = 1'b0, p_busy = 1'b0;
    logic [2:0]  bi;

    // ADC model: drives data bit 7..0 after rising edges 17..24 when SDIO is released.
    assign bi = 3'(24 - edges);
    assign sdio_i[g] = oe[g] ? sdio_o[g] :
                       ((edges >= 17 && edges <= 24) ? adc_byte[g][bi] : 1'b0);

    // Frame monitor sampled on the falling clk edge.
    always @(negedge clk) begin
      rec_t r;
      if (!reset_n) begin
        edges = 0; busy_cyc = 0; p_sclk = 1'b0; p_busy = 1'b0;
      end else begin
        if (busy[g] && !p_busy) begin
          busy_cyc = 0; edges = 0; fr = '0; oe_low = 0; gap = 0; rv_cnt = 0; rv_at = 0;
        end
        if (busy[g]) busy_cyc++;
        if (!csb[g]) begin
          if (sclk[g] && !p_sclk) begin
            fr = {fr[22:0], sdio_o[g]};
            edges++;
          end
          if (!oe[g]) oe_low++;
        end else if (busy[g]) begin
          gap++;
        end
        if (rd_valid[g]) begin
          rv_cnt++;
          rv_at = busy_cyc;
          rdd   = rd_data[g];
        end
        if (!busy[g] && p_busy) begin
          r.rw = fr[23]; r.fr = fr; r.edges = edges; r.busy = busy_cyc; r.oe_low = oe_low;
          r.gap = gap; r.rv_cnt = rv_cnt; r.rv_at = rv_at; r.rdd = rdd;
          if (g == 0) obs_a.push_back(r);
          else        obs_b.push_back(r);
        end
        p_sclk = sclk[g];
        p_busy = busy[g];
      end
    end
  end

  function automatic rec_t model(input logic [31:0] cmd, input int d, input logic [7:0] b);
    rec_t r;
    r.rw     = cmd[31];
    r.fr     = {cmd[31], 7'b0, cmd[23:16], cmd[15:8]};
    r.edges  = 24;
    r.busy   = 52 * d;
    r.oe_low = cmd[31] ? 17 * d : 0;
    r.gap    = 2 * d;
    r.rv_cnt = cmd[31] ? 1 : 0;
    r.rv_at  = cmd[31] ? 49 * d + 1 : 0;
    r.rdd    = b;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int inst, input logic [31:0] cmd, input logic [7:0] b);
    @(negedge clk);
    if (inst == 0) exp_a.push_back(model(cmd, 8, b));
    else           exp_b.push_back(model(cmd, 2, b));
    adc_data[inst] = cmd;
    adc_byte[inst] = b;
    start[inst]    = 1'b1;
    @(negedge clk);
    start[inst] = 1'b0;
    if (inst == 1) adc_data[1] = 32'hFFFF_FFFF;
  endtask

  task automatic check_frame(input int inst);
    rec_t        e, o;
    int          n;
    logic [23:0] m;
    n = 0;
    for (int t = 0; t < 3000; t++) begin
      n = (inst == 0) ? obs_a.size() : obs_b.size();
      if (n != 0) break;
      @(negedge clk);
    end
    chk("frame_done", (n != 0), 1);
    if (n == 0) return;
    if (inst == 0) begin e = exp_a.pop_front(); o = obs_a.pop_front(); end
    else           begin e = exp_b.pop_front(); o = obs_b.pop_front(); end
    m = e.rw ? 24'hFFFF00 : 24'hFFFFFF;
    chk("frame_bits", o.fr & m, e.fr & m);
    chk("sclk_rises", o.edges, e.edges);
    chk("busy_cycles", o.busy, e.busy);
    chk("oe_low_cycles", o.oe_low, e.oe_low);
    chk("csb_gap", o.gap, e.gap);
    chk("rd_valid_pulses", o.rv_cnt, e.rv_cnt);
    chk("rd_valid_cycle", o.rv_at, e.rv_at);
    if (e.rw) chk("rd_data", o.rdd, e.rdd);
  endtask

  initial begin
    clk = 1'b0; reset_n = 1'b1; start = '0;
    adc_data[0] = '0; adc_data[1] = '0; adc_byte[0] = '0; adc_byte[1] = '0;

    // Reset values
    #1 reset_n = 1'b0;
    #1;
    chk("rst_busy", busy[0], 0);
    chk("rst_csb", csb[0], 1);
    chk("rst_sclk", sclk[0], 0);
    chk("rst_sdio", sdio_o[0], 0);
    chk("rst_oe", oe[0], 0);
    chk("rst_rd_data", rd_data[0], 8'h00);
    chk("rst_rd_valid", rd_valid[0], 0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;

    // Writes and a read at CLK_DIV=8
    send(0, 32'h000D0C0C, 8'h00); check_frame(0);
    send(0, 32'h00FF0101, 8'h00); check_frame(0);
    send(0, 32'h80010000, 8'hA5); check_frame(0);
    chk("rd_data_held", rd_data[0], 8'hA5);

    // Start pulses while busy at edges 10, 100, 415 are dropped; edge 417 is accepted
    send(0, 32'h00123456, 8'h00);
    repeat (9)   @(negedge clk); adc_data[0] = 32'h80FF0000; start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    repeat (89)  @(negedge clk); start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    repeat (314) @(negedge clk); start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    send(0, 32'h00AB55AA, 8'h00);
    check_frame(0);
    check_frame(0);
    repeat (100) @(negedge clk);
    chk("no_extra_frame", obs_a.size(), 0);

    // Asynchronous reset at bit 12 of a frame
    send(0, 32'h00C3A55A, 8'h00);
    for (int t = 0; t < 2000 && g_dut[0].edges != 12; t++) @(negedge clk);
    chk("reached_bit12", g_dut[0].edges, 12);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_csb", csb[0], 1);
    chk("arst_sclk", sclk[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_oe", oe[0], 0);
    chk("arst_rd_data", rd_data[0], 8'h00);
    void'(exp_a.pop_back());
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    send(0, 32'h00429900, 8'h00); check_frame(0);

    // CLK_DIV=2 with the command word overwritten after acceptance
    send(1, 32'h00A53C00, 8'h00); check_frame(1);
    send(1, 32'h80770000, 8'h3C); check_frame(1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
